bcd_clock_display_scan: RTL and testbench

- Display-side consumer of the clock counters' packed-BCD time outputs: hour (tens 2b, units 4b) and minute (tens 3b, units 4b).
- Snapshots the time once per frame, decodes each BCD digit to 7-segment, and time-multiplexes four common-cathode/anode digits.
- Sits between the hour/minute counter CPLD outputs and the LED display pins, on the free-running board clock.

---
 rtl/bcd_clock_display_scan.sv | 139 +++++++++++++
 tb/tb_bcd_clock_display_scan.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_clock_display_scan.sv
// Four-digit multiplexed 7-segment driver for packed-BCD hh:mm with per-frame snapshot.
// Optional COLON_BLINK_EN macro makes the colon blink every BLINK_FRAMES frames.
module bcd_clock_display_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLINK_FRAMES   = 125
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [5:0] hour_bcd,
  input  logic [6:0] min_bcd,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig,
  output logic       frame_start
);
  localparam int            PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST    = PW'(SCAN_DIV - 1);
  localparam logic          POL     = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF = {7{POL}};
  localparam logic [6:0]    DASH    = 7'h01;

  logic [PW-1:0] presc;
  logic [1:0]    idx, disp_idx;
  logic          shown, retry, colon_phase;
  logic [5:0]    h_s1, h_s2, snap_h;
  logic [6:0]    m_s1, m_s2, snap_m;
  logic          tick, wrap, stable, hour_bad, min_bad;
  logic [6:0]    raw_seg;
  logic          raw_dp;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'h7E;
      4'd1: dec7 = 7'h30;
      4'd2: dec7 = 7'h6D;
      4'd3: dec7 = 7'h79;
      4'd4: dec7 = 7'h33;
      4'd5: dec7 = 7'h5B;
      4'd6: dec7 = 7'h5F;
      4'd7: dec7 = 7'h70;
      4'd8: dec7 = 7'h7F;
      4'd9: dec7 = 7'h7B;
      default: dec7 = 7'h00;
    endcase
  endfunction

  assign tick     = (presc == LAST);
  assign wrap     = tick && (idx == 2'd3);
  assign stable   = (h_s1 == h_s2) && (m_s1 == m_s2);
  assign hour_bad = (snap_h[3:0] > 4'd9) || (snap_h[5:4] > 2'd2) || (snap_h > 6'h23);
  assign min_bad  = (snap_m[3:0] > 4'd9) || (snap_m[6:4] > 3'd5);

  // Pattern for the slot that is ending; it is shown during the next slot period.
  always_comb begin
    raw_seg = 7'h00;
    raw_dp  = 1'b0;
    case (idx)
      2'd0: raw_seg = hour_bad ? DASH :
                      (snap_h[5:4] == 2'd0) ? 7'h00 : dec7({2'b00, snap_h[5:4]});
      2'd1: begin
        raw_seg = hour_bad ? DASH : dec7(snap_h[3:0]);
        raw_dp  = colon_phase;
      end
      2'd2: raw_seg = min_bad ? DASH : dec7({1'b0, snap_m[6:4]});
      default: raw_seg = min_bad ? DASH : dec7(snap_m[3:0]);
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc       <= '0;
      idx         <= 2'd0;
      disp_idx    <= 2'd0;
      shown       <= 1'b0;
      retry       <= 1'b0;
      h_s1        <= 6'h00;
      h_s2        <= 6'h00;
      m_s1        <= 7'h00;
      m_s2        <= 7'h00;
      snap_h      <= 6'h00;
      snap_m      <= 7'h00;
      seg         <= SEG_OFF;
      dp          <= POL;
      dig         <= 4'b0000;
      frame_start <= 1'b0;
    end else begin
      h_s1        <= hour_bcd;
      h_s2        <= h_s1;
      m_s1        <= min_bcd;
      m_s2        <= m_s1;
      presc       <= tick ? '0 : presc + 1'b1;
      frame_start <= wrap;
      // One-hot only from the third clock of a slot: two dark clocks suppress ghosting.
      dig <= (shown && !tick && (presc != '0) && !blank) ? (4'b1000 >> disp_idx) : 4'b0000;
      if (tick) begin
        idx      <= idx + 2'd1;
        disp_idx <= idx;
        shown    <= 1'b1;
        seg      <= raw_seg ^ {7{POL}};
        dp       <= raw_dp ^ POL;
      end
      if (tick && (wrap || retry)) begin
        if (stable) begin
          snap_h <= h_s2;
          snap_m <= m_s2;
          retry  <= 1'b0;
        end else begin
          retry  <= 1'b1;
        end
      end
    end
  end

`ifdef COLON_BLINK_EN
  localparam int            FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      frame_cnt   <= '0;
      colon_phase <= 1'b1;
    end else if (wrap) begin
      if (frame_cnt == FLAST) begin
        frame_cnt   <= '0;
        colon_phase <= ~colon_phase;
      end else begin
        frame_cnt   <= frame_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_blink_frames;
  assign unused_blink_frames = ^BLINK_FRAMES;
  assign colon_phase = 1'b1;
`endif
endmodule

// File: tb/tb_bcd_clock_display_scan.sv
// Directed bench for bcd_clock_display_scan with SCAN_DIV=4, SEG_ACTIVE_LOW=1.
module tb_bcd_clock_display_scan;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [5:0] hour_bcd = 6'h00;
  logic [6:0] min_bcd = 7'h00;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] dig;
  logic       frame_start;
  int vectors = 0;
  int miscompares = 0;

  bcd_clock_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .BLINK_FRAMES(2)) dut (
    .clk(clk), .clr(clr), .hour_bcd(hour_bcd), .min_bcd(min_bcd), .blank(blank),
    .seg(seg), .dp(dp), .dig(dig), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic wait_frame_start();
    int n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_start_timeout: frame_start=%b, required 1 within 64 clks", frame_start);
    end
  endtask

  // Samples the one-hot phase of each of the four slots after a frame_start seen `lead` clks ago.
  task automatic capture(input int lead, output logic [15:0] digs, output logic [27:0] segs,
                         output logic [3:0] dps);
    repeat (6 - lead) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (4) @(negedge clk);
      digs[4*k +: 4] = dig;
      segs[7*k +: 7] = seg;
      dps[k]         = dp;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (dig !== 4'b0000 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: dig=%b seg=%h dp=%b fs=%b, required 0000 7f 1 0", dig, seg, dp, frame_start);
    end
    clr = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (dig !== 4'b0000) begin
      miscompares++;
      $display("FAIL guard_clk4: dig=%b, required 0000", dig);
    end
    @(negedge clk);
    vectors++;
    if (dig !== 4'b0000) begin
      miscompares++;
      $display("FAIL guard_clk5: dig=%b, required 0000", dig);
    end
    @(negedge clk);
    vectors++;
    if (dig !== 4'b1000 || seg !== 7'h7F) begin
      miscompares++;
      $display("FAIL first_slot: dig=%b seg=%h, required 1000 7f", dig, seg);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (dig !== 4'b0100 || seg !== 7'h01 || dp !== 1'b0) begin
      miscompares++;
      $display("FAIL slot1_after_reset: dig=%b seg=%h dp=%b, required 0100 01 0", dig, seg, dp);
    end
    #2 clr = 1'b1;
    #1;
    vectors++;
    if (dig !== 4'b0000 || seg !== 7'h7F || dp !== 1'b1) begin
      miscompares++;
      $display("FAIL async_clr: dig=%b seg=%h dp=%b, required 0000 7f 1", dig, seg, dp);
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (dig !== 4'b0000) begin
      miscompares++;
      $display("FAIL rerelease_guard: dig=%b, required 0000", dig);
    end
    @(negedge clk);
    vectors++;
    if (dig !== 4'b1000 || seg !== 7'h7F) begin
      miscompares++;
      $display("FAIL rerelease_first: dig=%b seg=%h, required 1000 7f", dig, seg);
    end
  endtask

  task automatic test_time_2359();
    logic [15:0] d; logic [27:0] s; logic [3:0] p;
    logic [6:0] es [4] = '{7'h12, 7'h06, 7'h24, 7'h04};
    logic [3:0] ep = 4'b1101;
    logic [3:0] hot = 4'b1000;
    hour_bcd = 6'h23; min_bcd = 7'h59;
    wait_frame_start();
    wait_frame_start();
    capture(0, d, s, p);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (d[4*k +: 4] !== (hot >> k) || s[7*k +: 7] !== es[k] || p[k] !== ep[k]) begin
        miscompares++;
        $display("FAIL t2359_slot%0d: dig=%b seg=%h dp=%b, required %b %h %b",
                 k, d[4*k +: 4], s[7*k +: 7], p[k], hot >> k, es[k], ep[k]);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] d; logic [27:0] s; logic [3:0] p;
    logic [6:0] es [4] = '{7'h7F, 7'h0F, 7'h01, 7'h01};
    logic [3:0] hot = 4'b1000;
    hour_bcd = 6'h07; min_bcd = 7'h00;
    wait_frame_start();
    wait_frame_start();
    capture(0, d, s, p);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (d[4*k +: 4] !== (hot >> k) || s[7*k +: 7] !== es[k]) begin
        miscompares++;
        $display("FAIL t0700_slot%0d: dig=%b seg=%h, required %b %h", k, d[4*k +: 4], s[7*k +: 7], hot >> k, es[k]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [15:0] d; logic [27:0] s; logic [3:0] p;
    logic [6:0] es [4] = '{7'h4F, 7'h12, 7'h7E, 7'h7E};
    hour_bcd = 6'h2A; min_bcd = 7'h60;
    wait_frame_start();
    wait_frame_start();
    capture(0, d, s, p);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (s[7*k +: 7] !== 7'h7E) begin
        miscompares++;
        $display("FAIL dash_slot%0d: seg=%h, required 7e", k, s[7*k +: 7]);
      end
    end
    hour_bcd = 6'h12;
    wait_frame_start();
    wait_frame_start();
    capture(0, d, s, p);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (s[7*k +: 7] !== es[k]) begin
        miscompares++;
        $display("FAIL fixhour_slot%0d: seg=%h, required %h", k, s[7*k +: 7], es[k]);
      end
    end
  endtask

  task automatic test_snapshot_hold();
    logic [15:0] d; logic [27:0] s; logic [3:0] p;
    logic [6:0] eo [4] = '{7'h4F, 7'h12, 7'h7E, 7'h7E};
    logic [6:0] en [4] = '{7'h12, 7'h06, 7'h24, 7'h04};
    wait_frame_start();
    @(negedge clk);
    hour_bcd = 6'h23; min_bcd = 7'h59;
    capture(1, d, s, p);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (s[7*k +: 7] !== eo[k]) begin
        miscompares++;
        $display("FAIL midframe_hold_slot%0d: seg=%h, required %h", k, s[7*k +: 7], eo[k]);
      end
    end
    wait_frame_start();
    capture(0, d, s, p);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (s[7*k +: 7] !== en[k]) begin
        miscompares++;
        $display("FAIL next_frame_slot%0d: seg=%h, required %h", k, s[7*k +: 7], en[k]);
      end
    end
  endtask

  task automatic test_retry();
    logic [15:0] d; logic [27:0] s; logic [3:0] p;
    logic [6:0] es [4] = '{7'h12, 7'h0F, 7'h01, 7'h01};
    wait_frame_start();
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 1) min_bcd = 7'h00;
      if (k == 16) begin
        vectors++;
        if (frame_start !== 1'b1) begin
          miscompares++;
          $display("FAIL unstable_wrap_fs: frame_start=%b, required 1", frame_start);
        end
      end
      if (k >= 10) hour_bcd = (k % 2 == 1) ? 6'h07 : 6'h12;
    end
    capture(1, d, s, p);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (s[7*k +: 7] !== es[k]) begin
        miscompares++;
        $display("FAIL retry_slot%0d: seg=%h, required %h", k, s[7*k +: 7], es[k]);
      end
    end
  endtask

  task automatic test_blank();
    wait_frame_start();
    @(negedge clk);
    blank = 1'b1;
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      vectors++;
      if (dig !== 4'b0000) begin
        miscompares++;
        $display("FAIL blank_clk%0d: dig=%b, required 0000", k, dig);
      end
    end
    blank = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (dig !== 4'b0010 || seg !== 7'h01) begin
      miscompares++;
      $display("FAIL blank_resume: dig=%b seg=%h, required 0010 01", dig, seg);
    end
  endtask

`ifdef COLON_BLINK_EN
  task automatic test_colon_blink();
    logic [3:0] c;
    for (int f = 0; f < 4; f++) begin
      wait_frame_start();
      repeat (10) @(negedge clk);
      c[f] = dp;
      vectors++;
      if (dig !== 4'b0100) begin
        miscompares++;
        $display("FAIL blink_slot_f%0d: dig=%b, required 0100", f, dig);
      end
    end
    vectors++;
    if (c[0] === c[2] || c[1] === c[3]) begin
      miscompares++;
      $display("FAIL colon_blink: dp per frame=%b, required period of 4 frames", c);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_time_2359();
    test_leading_zero();
    test_invalid();
    test_snapshot_hold();
    test_retry();
    test_blank();
`ifdef COLON_BLINK_EN
    test_colon_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
